// File: rtl/sm_accumulator_16.sv
// Digit-serial sign-magnitude accumulator: adds signed operands into a running total, one DIGIT_W-bit digit per cycle.
// Build option: define SMACC_SATURATE_EN to saturate the magnitude on add overflow instead of wrapping.
module sm_accumulator_16 #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Mag_in16,
    input  logic             Sign_in,
    input  logic             Clear,
    output logic [WIDTH-1:0] Acc_mag16,
    output logic             Acc_negative,
    output logic             Overflow,
    output logic             Done
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int IDX_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_NEGATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;
    logic             sub_q, sub_d;
    logic             res_neg_q, res_neg_d;
    logic [WIDTH-1:0] acc_mag_q, acc_mag_d;
    logic             acc_neg_q, acc_neg_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [DIGIT_W:0] step_s;
    logic [DIGIT_W:0] neg_step_s;
    logic             op_neg_s;

    function automatic logic [DIGIT_W:0] digit_step(input logic [DIGIT_W-1:0] a,
                                                     input logic [DIGIT_W-1:0] b,
                                                     input logic             cin,
                                                     input logic             sub);
        if (sub) begin
            digit_step = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, cin};
        end else begin
            digit_step = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        end
    endfunction

    // Low digits of the rotating working registers feed the digit datapath; top bit is carry/borrow out.
    assign step_s     = digit_step(work_q[DIGIT_W-1:0], opb_q[DIGIT_W-1:0], cy_q, sub_q);
    assign neg_step_s = {1'b0, ~work_q[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, cy_q};
    // A negative zero operand is treated as +0 when choosing add or subtract.
    assign op_neg_s   = Sign_in & (|Mag_in16);

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        opb_d     = opb_q;
        work_d    = work_q;
        idx_d     = idx_q;
        cy_d      = cy_q;
        sub_d     = sub_q;
        res_neg_d = res_neg_q;
        acc_mag_d = acc_mag_q;
        acc_neg_d = acc_neg_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (Clear) begin
                    acc_mag_d = {WIDTH{1'b0}};
                    acc_neg_d = 1'b0;
                    ovf_d     = 1'b0;
                end else if (In_valid) begin
                    opb_d     = Mag_in16;
                    work_d    = acc_mag_q;
                    idx_d     = {IDX_W{1'b0}};
                    cy_d      = 1'b0;
                    sub_d     = (op_neg_s != acc_neg_q);
                    res_neg_d = acc_neg_q;
                    state_d   = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                // Digits rotate in at the top, so after N steps the result sits in place.
                if (idx_q != IDX_W'(N)) begin
                    work_d = {step_s[DIGIT_W-1:0], work_q[WIDTH-1:DIGIT_W]};
                    opb_d  = opb_q >> DIGIT_W;
                    cy_d   = step_s[DIGIT_W];
                    idx_d  = idx_q + IDX_W'(1);
                end else if (!sub_q) begin
                    if (cy_q) begin
                        ovf_d = 1'b1;
`ifdef SMACC_SATURATE_EN
                        acc_mag_d = {WIDTH{1'b1}};
                        acc_neg_d = res_neg_q;
`else
                        acc_mag_d = work_q;
                        acc_neg_d = res_neg_q & (|work_q);
`endif
                    end else begin
                        acc_mag_d = work_q;
                        acc_neg_d = res_neg_q & (|work_q);
                    end
                    state_d = S_DONE;
                end else if (cy_q) begin
                    idx_d     = {IDX_W{1'b0}};
                    cy_d      = 1'b1;
                    res_neg_d = ~res_neg_q;
                    state_d   = S_NEGATE;
                end else begin
                    acc_mag_d = work_q;
                    acc_neg_d = res_neg_q & (|work_q);
                    state_d   = S_DONE;
                end
            end
            S_NEGATE: begin
                work_d = {neg_step_s[DIGIT_W-1:0], work_q[WIDTH-1:DIGIT_W]};
                cy_d   = neg_step_s[DIGIT_W];
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    acc_mag_d = work_d;
                    acc_neg_d = res_neg_q & (|work_d);
                    state_d   = S_DONE;
                end else begin
                    state_d = S_NEGATE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opb_q     <= {WIDTH{1'b0}};
            work_q    <= {WIDTH{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            cy_q      <= 1'b0;
            sub_q     <= 1'b0;
            res_neg_q <= 1'b0;
            acc_mag_q <= {WIDTH{1'b0}};
            acc_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            opb_q     <= opb_d;
            work_q    <= work_d;
            idx_q     <= idx_d;
            cy_q      <= cy_d;
            sub_q     <= sub_d;
            res_neg_q <= res_neg_d;
            acc_mag_q <= acc_mag_d;
            acc_neg_q <= acc_neg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign Acc_mag16    = acc_mag_q;
    assign Acc_negative = acc_neg_q;
    assign Overflow     = ovf_q;
    assign Done         = done_q;
    assign In_ready     = ready_q;

endmodule

// File: tb/tb_sm_accumulator_16.sv
// Directed self-checking bench for sm_accumulator_16; expectations follow the SMACC_SATURATE_EN setting.
module tb_sm_accumulator_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        In_valid;
    logic        In_ready;
    logic [15:0] Mag_in16;
    logic        Sign_in;
    logic        Clear;
    logic [15:0] Acc_mag16;
    logic        Acc_negative;
    logic        Overflow;
    logic        Done;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] mdl_mag;

    sm_accumulator_16 #(.WIDTH(16), .DIGIT_W(4)) dut (
        .clk(clk), .reset(reset), .In_valid(In_valid), .In_ready(In_ready),
        .Mag_in16(Mag_in16), .Sign_in(Sign_in), .Clear(Clear),
        .Acc_mag16(Acc_mag16), .Acc_negative(Acc_negative),
        .Overflow(Overflow), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        mdl_mag = 16'h0000;
    endtask

    // Issue one operand, measure edges from accept to Done, then check the result.
    task automatic do_op(input string tag, input logic [15:0] mag, input logic sgn,
                         input int exp_lat, input logic [15:0] exp_mag,
                         input logic exp_neg, input logic exp_ovf);
        int lat;
        lat = 0;
        chk({tag, "_ready_pre"}, {31'd0, In_ready}, 32'd1);
        In_valid = 1'b1;
        Mag_in16 = mag;
        Sign_in  = sgn;
        tick();
        In_valid = 1'b0;
        Mag_in16 = 16'h0000;
        Sign_in  = 1'b0;
        chk({tag, "_ready_busy"}, {31'd0, In_ready}, 32'd0);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            tick();
            if (Done === 1'b1) begin
                lat = k;
            end else if (k == 2) begin
                chk({tag, "_hold"}, {16'd0, Acc_mag16}, {16'd0, mdl_mag});
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_mag"}, {16'd0, Acc_mag16}, {16'd0, exp_mag});
        chk({tag, "_neg"}, {31'd0, Acc_negative}, {31'd0, exp_neg});
        chk({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, exp_ovf});
        tick();
        chk({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        chk({tag, "_ready_post"}, {31'd0, In_ready}, 32'd1);
        mdl_mag = exp_mag;
    endtask

    initial begin
        reset    = 1'b1;
        In_valid = 1'b0;
        Mag_in16 = 16'h0000;
        Sign_in  = 1'b0;
        Clear    = 1'b0;
        mdl_mag  = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_mag", {16'd0, Acc_mag16}, 32'd0);
        chk("rst_neg", {31'd0, Acc_negative}, 32'd0);
        chk("rst_ovf", {31'd0, Overflow}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_ready", {31'd0, In_ready}, 32'd1);

        do_op("add1", 16'h1234, 1'b0, 5, 16'h1234, 1'b0, 1'b0);
        do_op("add2", 16'h0F0F, 1'b0, 5, 16'h2143, 1'b0, 1'b0);

        do_clear();
        do_op("p5", 16'h0005, 1'b0, 5, 16'h0005, 1'b0, 1'b0);
        do_op("sub_neg", 16'h0008, 1'b1, 9, 16'h0003, 1'b1, 1'b0);

        do_clear();
        do_op("m10", 16'h0010, 1'b1, 9, 16'h0010, 1'b1, 1'b0);
        do_op("to_zero", 16'h0010, 1'b0, 5, 16'h0000, 1'b0, 1'b0);
        do_op("neg_zero_op", 16'h0000, 1'b1, 5, 16'h0000, 1'b0, 1'b0);

        do_clear();
        do_op("ffff", 16'hFFFF, 1'b0, 5, 16'hFFFF, 1'b0, 1'b0);
`ifdef SMACC_SATURATE_EN
        do_op("ovf", 16'h0002, 1'b0, 5, 16'hFFFF, 1'b0, 1'b1);
        do_op("ovf_sticky", 16'h0001, 1'b0, 5, 16'hFFFF, 1'b0, 1'b1);
`else
        do_op("ovf", 16'h0002, 1'b0, 5, 16'h0001, 1'b0, 1'b1);
        do_op("ovf_sticky", 16'h0001, 1'b0, 5, 16'h0002, 1'b0, 1'b1);
`endif

        // Clear wins over a simultaneous operand.
        Clear    = 1'b1;
        In_valid = 1'b1;
        Mag_in16 = 16'h0042;
        tick();
        Clear    = 1'b0;
        In_valid = 1'b0;
        chk("clr_mag", {16'd0, Acc_mag16}, 32'd0);
        chk("clr_ovf", {31'd0, Overflow}, 32'd0);
        chk("clr_ready", {31'd0, In_ready}, 32'd1);
        tick();
        chk("clr_no_accept", {31'd0, In_ready}, 32'd1);
        mdl_mag = 16'h0000;

        // Continuous In_valid: second operand taken only after Done.
        In_valid = 1'b1;
        Mag_in16 = 16'h0001;
        Sign_in  = 1'b0;
        tick();
        Mag_in16 = 16'h0002;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("b2b_ready_busy", {31'd0, In_ready}, 32'd0);
        end
        chk("b2b_done1", {31'd0, Done}, 32'd1);
        chk("b2b_mag1", {16'd0, Acc_mag16}, 32'h0001);
        tick();
        chk("b2b_ready_idle", {31'd0, In_ready}, 32'd1);
        tick();
        In_valid = 1'b0;
        chk("b2b_accept2", {31'd0, In_ready}, 32'd0);
        for (int k = 1; k <= 5; k++) tick();
        chk("b2b_done2", {31'd0, Done}, 32'd1);
        chk("b2b_mag2", {16'd0, Acc_mag16}, 32'h0003);
        tick();

        // Reset while negating.
        do_clear();
        do_op("pre_rst", 16'h0001, 1'b0, 5, 16'h0001, 1'b0, 1'b0);
        In_valid = 1'b1;
        Mag_in16 = 16'h0100;
        Sign_in  = 1'b1;
        tick();
        In_valid = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        chk("negate_busy", {31'd0, In_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_mag", {16'd0, Acc_mag16}, 32'd0);
        chk("mid_rst_neg", {31'd0, Acc_negative}, 32'd0);
        chk("mid_rst_done", {31'd0, Done}, 32'd0);
        chk("mid_rst_ready", {31'd0, In_ready}, 32'd1);
        mdl_mag = 16'h0000;
        do_op("post_rst", 16'h0007, 1'b0, 5, 16'h0007, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
